// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and stalls on the mem_ready handshake with a saturating wait counter.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_MAX    = 8'(MEM_WAIT_MAX);
    localparam logic [7:0] WAIT_MAX_M1 = 8'(MEM_WAIT_MAX - 1);

    state_t     state_reg, state_next;
    logic [5:0] op_reg, op_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       timeout_reg, timeout_next;
    logic       waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            op_reg       <= '0;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        op_next    = op_reg;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_next = Op;
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            // Latched opcode only: Op may already belong to something else here.
            S_MEMADR: begin
                if (op_reg == OP_LW)      state_next = S_MEMRD;
                else if (op_reg == OP_SW) state_next = S_MEMWR;
                else                      state_next = S_FETCH;
            end
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_RCOMP;
            S_RCOMP:  state_next = S_FETCH;
            S_BEQ:    state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    assign waiting = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);

    // Any state change clears the count, so each wait state starts fresh on entry.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = 1'b0;
        if (!waiting || (state_next != state_reg)) begin
            wait_cnt_next = '0;
        end else if (!mem_ready && (wait_cnt_reg != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
            timeout_next  = (wait_cnt_reg == WAIT_MAX_M1);
        end
    end

    // Outputs are masked by rst_n so a reset mid-instruction drops writes immediately.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (rst_n) begin
            mem_timeout = timeout_reg;
            case (state_reg)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !((Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                                   (Op == OP_BEQ) || (Op == OP_J));
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RCOMP: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, a memory stall,
// the wait timeout and a reset abort, checking against hand-computed values.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic       illegal_op, mem_timeout;
    logic [3:0] state;
    logic [17:0] all_outs;

    int checks_cnt;
    int failures;

    multicycle_control #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state(state)
    );

    assign all_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                       RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource,
                       illegal_op, mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land on the falling edge for sampling/driving.
    task automatic tick(input string tag, input logic [3:0] exp_state);
        @(posedge clk);
        @(negedge clk);
        check(tag, 32'(state), 32'(exp_state));
    endtask

    initial begin
        checks_cnt = 0;
        failures   = 0;
        rst_n      = 1'b0;
        mem_ready  = 1'b1;
        Op         = 6'b000000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'(all_outs), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        #1;
        check("fetch_memread", 32'(MemRead), 32'd1);
        check("fetch_alusrcb", 32'(ALUSrcB), 32'd1);
        check("fetch_irwrite", 32'(IRWrite), 32'd1);
        $display("txn reset done");

        // R-type: 0,1,6,7,0
        tick("r_s1", 4'd1);
        check("decode_alusrcb", 32'(ALUSrcB), 32'd3);
        tick("r_s6", 4'd6);
        check("exec_aluop", 32'(ALUOp), 32'd2);
        check("exec_alusrca", 32'(ALUSrcA), 32'd1);
        tick("r_s7", 4'd7);
        check("rcomp_regwrite", 32'(RegWrite), 32'd1);
        check("rcomp_regdst", 32'(RegDst), 32'd1);
        tick("r_s0", 4'd0);
        $display("txn rtype done");

        // lw with a two-cycle stall in MEMRD; Op changes after DECODE must be ignored
        Op = 6'b100011;
        tick("lw_s1", 4'd1);
        tick("lw_s2", 4'd2);
        Op        = 6'b101011;
        mem_ready = 1'b0;
        tick("lw_s3a", 4'd3);
        check("memrd_memread", 32'(MemRead), 32'd1);
        check("memrd_iord", 32'(IorD), 32'd1);
        tick("lw_s3b", 4'd3);
        tick("lw_s3c", 4'd3);
        mem_ready = 1'b1;
        tick("lw_s4", 4'd4);
        check("memwb_memtoreg", 32'(MemtoReg), 32'd1);
        check("memwb_regwrite", 32'(RegWrite), 32'd1);
        tick("lw_s0", 4'd0);
        $display("txn lw done");

        // sw: 0,1,2,5,0
        Op = 6'b101011;
        tick("sw_s1", 4'd1);
        tick("sw_s2", 4'd2);
        check("memadr_memwrite", 32'(MemWrite), 32'd0);
        tick("sw_s5", 4'd5);
        check("memwr_memwrite", 32'(MemWrite), 32'd1);
        check("memwr_iord", 32'(IorD), 32'd1);
        tick("sw_s0", 4'd0);
        check("sw_after_memwrite", 32'(MemWrite), 32'd0);
        $display("txn sw done");

        // beq: 0,1,8,0
        Op = 6'b000100;
        tick("beq_s1", 4'd1);
        tick("beq_s8", 4'd8);
        check("beq_aluop", 32'(ALUOp), 32'd1);
        check("beq_pcwritecond", 32'(PCWriteCond), 32'd1);
        check("beq_pcsource", 32'(PCSource), 32'd1);
        tick("beq_s0", 4'd0);
        $display("txn beq done");

        // illegal opcode
        Op = 6'b111111;
        tick("ill_s1", 4'd1);
        check("ill_pulse", 32'(illegal_op), 32'd1);
        tick("ill_s0", 4'd0);
        check("ill_clear", 32'(illegal_op), 32'd0);
        $display("txn illegal done");

        // jump: 0,1,9,0
        Op = 6'b000010;
        tick("j_s1", 4'd1);
        check("j_decode_no_ill", 32'(illegal_op), 32'd0);
        tick("j_s9", 4'd9);
        check("j_pcwrite", 32'(PCWrite), 32'd1);
        check("j_pcsource", 32'(PCSource), 32'd2);
        tick("j_s0", 4'd0);
        $display("txn jump done");

        // FETCH stall: timeout after the 4th wait cycle, once, state held
        mem_ready = 1'b0;
        #1;
        check("stall_irwrite", 32'(IRWrite), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick("to_state", 4'd0);
            check($sformatf("to_pulse_%0d", i), 32'(mem_timeout), (i == 4) ? 32'd1 : 32'd0);
        end
        $display("txn timeout done");

        // reset abort during MEMWR
        mem_ready = 1'b1;
        Op        = 6'b101011;
        tick("ab_s1", 4'd1);
        tick("ab_s2", 4'd2);
        mem_ready = 1'b0;
        tick("ab_s5", 4'd5);
        check("ab_memwrite_pre", 32'(MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ab_memwrite_drop", 32'(MemWrite), 32'd0);
        check("ab_state", 32'(state), 32'd0);
        check("ab_outs", 32'(all_outs), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        check("ab_refetch", 32'(MemRead), 32'd1);
        $display("txn reset_abort done");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures);
        $finish;
    end

endmodule
